// File: rtl/cnt_dn_timer_pkg.sv
// Shared constants, types and the binary-to-BCD helper for the countdown timer.
package cnt_dn_timer_pkg;

    localparam int CNT_W           = 8;
    localparam int CLK_DIV_DEFAULT = 25_000_000;
    localparam int BCD_MAX         = 99;
    localparam int N_DIR           = 2;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t G_TIME_DEFAULT = 8'd28;

    // Two-digit BCD of a seconds count; anything above 99 shows as 99.
    function automatic logic [7:0] to_bcd(input cnt_t v);
        logic [7:0] r;
        if (v > cnt_t'(BCD_MAX)) begin
            r = 8'h99;
        end else begin
            r = {4'(v / cnt_t'(10)), 4'(v % cnt_t'(10))};
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_dn_timer_tick_gen.sv
// Free-running prescaler producing the 1 Hz flash clock and a once-per-second tick.
module tick_gen
    import cnt_dn_timer_pkg::*;
#(
    parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic clk_fst,
    input  logic rst,
    output logic clk_cnt_dn,
    output logic sec_tick
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic          clk_cnt_dn_q;
    logic          clk_cnt_dn_d;
    logic          half_tick;

    // Prescaler wrap and square-wave toggle on every half-second boundary.
    always_comb begin
        half_tick    = (presc_q == PRESC_LAST);
        presc_d      = half_tick ? '0 : presc_q + PW'(1);
        clk_cnt_dn_d = clk_cnt_dn_q ^ half_tick;
    end

    // State registers; never restarted except by reset.
    always_ff @(posedge clk_fst or negedge rst) begin
        if (!rst) begin
            presc_q      <= '0;
            clk_cnt_dn_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            clk_cnt_dn_q <= clk_cnt_dn_d;
        end
    end

    // The second boundary is the half-tick on which the square wave falls.
    assign sec_tick   = half_tick & clk_cnt_dn_q;
    assign clk_cnt_dn = clk_cnt_dn_q;

endmodule

// File: rtl/cnt_dn_timer.sv
// Two-direction green-phase countdown timer with a registered BCD display output.
module cnt_dn_timer
    import cnt_dn_timer_pkg::*;
#(
    parameter int   CLK_DIV = CLK_DIV_DEFAULT,
    parameter cnt_t G_TIME  = G_TIME_DEFAULT
) (
    input  logic             clk_fst,
    input  logic             rst,
    input  logic             day_night,
    input  logic             g1_en,
    input  logic             g2_en,
    output logic             clk_cnt_dn,
    output logic             sec_tick,
    output logic [CNT_W-1:0] g1_cnt,
    output logic [CNT_W-1:0] g2_cnt,
    output logic [7:0]       disp_bcd
);

    logic [N_DIR-1:0] en_in;
    cnt_t             disp_src;
    logic [7:0]       disp_bcd_q;
    logic [7:0]       disp_bcd_d;

    assign en_in = {g2_en, g1_en};

    tick_gen #(
        .CLK_DIV    (CLK_DIV)
    ) u_tick_gen (
        .clk_fst    (clk_fst),
        .rst        (rst),
        .clk_cnt_dn (clk_cnt_dn),
        .sec_tick   (sec_tick)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_DIR; gi++) begin : g_dir
            logic en_q;
            logic en_d;
            logic en_rise;
            cnt_t cnt_q;
            cnt_t cnt_d;

            // Night clears everything; a fresh enable edge reloads ahead of the tick.
            always_comb begin
                en_rise = en_in[gi] & ~en_q;
                en_d    = en_in[gi];
                cnt_d   = cnt_q;
                if (!day_night) begin
                    en_d  = 1'b0;
                    cnt_d = '0;
                end else if (en_rise) begin
                    cnt_d = G_TIME;
                end else if (!en_in[gi]) begin
                    cnt_d = '0;
                end else if (sec_tick && (cnt_q != '0)) begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end

            // Per-direction counter and edge-detect registers.
            always_ff @(posedge clk_fst or negedge rst) begin
                if (!rst) begin
                    en_q  <= 1'b0;
                    cnt_q <= '0;
                end else begin
                    en_q  <= en_d;
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign g1_cnt = g_dir[0].cnt_q;
    assign g2_cnt = g_dir[1].cnt_q;

    // Display source: direction 1 wins when both are active.
    always_comb begin
        disp_src = '0;
        if (g1_en) begin
            disp_src = g1_cnt;
        end else if (g2_en) begin
            disp_src = g2_cnt;
        end
        disp_bcd_d = to_bcd(disp_src);
    end

    // Display register, one cycle behind the counters.
    always_ff @(posedge clk_fst or negedge rst) begin
        if (!rst) begin
            disp_bcd_q <= 8'h00;
        end else begin
            disp_bcd_q <= disp_bcd_d;
        end
    end

    assign disp_bcd = disp_bcd_q;

endmodule

// File: tb/tb_cnt_dn_timer.sv
// Directed, scoreboard-driven bench for cnt_dn_timer with CLK_DIV=4, G_TIME=28.
module tb_cnt_dn_timer;

    localparam int S_CLK   = 0;
    localparam int S_SEC   = 1;
    localparam int S_G1    = 2;
    localparam int S_G2    = 3;
    localparam int S_DISP  = 4;
    localparam int S_DISP2 = 5;

    typedef struct {
        string      tag;
        int         sig;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       day_night;
    logic       g1_en;
    logic       g2_en;
    logic       g1_en2;
    logic       clk_cnt_dn;
    logic       sec_tick;
    logic [7:0] g1_cnt;
    logic [7:0] g2_cnt;
    logic [7:0] disp_bcd;
    logic       clk_cnt_dn2;
    logic       sec_tick2;
    logic [7:0] g1_cnt2;
    logic [7:0] g2_cnt2;
    logic [7:0] disp_bcd2;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    cnt_dn_timer #(.CLK_DIV(4), .G_TIME(8'd28)) dut (
        .clk_fst    (clk),
        .rst        (rst),
        .day_night  (day_night),
        .g1_en      (g1_en),
        .g2_en      (g2_en),
        .clk_cnt_dn (clk_cnt_dn),
        .sec_tick   (sec_tick),
        .g1_cnt     (g1_cnt),
        .g2_cnt     (g2_cnt),
        .disp_bcd   (disp_bcd)
    );

    // Second instance with a load value above 99 to exercise display clamping.
    cnt_dn_timer #(.CLK_DIV(4), .G_TIME(8'd150)) dut_big (
        .clk_fst    (clk),
        .rst        (rst),
        .day_night  (day_night),
        .g1_en      (g1_en2),
        .g2_en      (1'b0),
        .clk_cnt_dn (clk_cnt_dn2),
        .sec_tick   (sec_tick2),
        .g1_cnt     (g1_cnt2),
        .g2_cnt     (g2_cnt2),
        .disp_bcd   (disp_bcd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] observe(input int sig);
        logic [7:0] o;
        case (sig)
            S_CLK:   o = {7'd0, clk_cnt_dn};
            S_SEC:   o = {7'd0, sec_tick};
            S_G1:    o = g1_cnt;
            S_G2:    o = g2_cnt;
            S_DISP:  o = disp_bcd;
            default: o = disp_bcd2;
        endcase
        return o;
    endfunction

    function automatic logic [7:0] bcd(input int v);
        logic [7:0] r;
        r = {4'(v / 10), 4'(v % 10)};
        return r;
    endfunction

    task automatic push(input string tag, input int sig, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t       e;
        logic [7:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sig);
            checks++;
            assert (o === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stops on a sample where sec_tick is high (checking the current sample first).
    task automatic wait_sec();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (sec_tick === 1'b1) found = 1'b1;
            else tick(1);
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL sec_tick_timeout observed=0 expected=1");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        rst       = 1'b0;
        day_night = 1'b1;
        g1_en     = 1'b0;
        g2_en     = 1'b0;
        g1_en2    = 1'b0;

        // Reset state
        tick(3);
        push("rst_clk", S_CLK, 8'd0);
        push("rst_sec", S_SEC, 8'd0);
        push("rst_g1", S_G1, 8'd0);
        push("rst_g2", S_G2, 8'd0);
        push("rst_disp", S_DISP, 8'h00);
        drain();

        // Free run: first half-tick CLK_DIV cycles after release, sec_tick every 8
        rst = 1'b1;
        tick(3);
        push("pre_half_clk", S_CLK, 8'd0);
        push("pre_half_sec", S_SEC, 8'd0);
        drain();
        tick(1);
        push("first_half_clk", S_CLK, 8'd1);
        drain();
        tick(3);
        push("first_sec", S_SEC, 8'd1);
        push("idle_g1", S_G1, 8'd0);
        drain();
        tick(1);
        push("after_sec_clk", S_CLK, 8'd0);
        push("after_sec_sec", S_SEC, 8'd0);
        drain();
        tick(7);
        push("second_sec", S_SEC, 8'd1);
        push("idle_g2", S_G2, 8'd0);
        drain();

        // Enable rises on a sec_tick cycle: load wins over decrement
        g1_en  = 1'b1;
        g1_en2 = 1'b1;
        tick(1);
        push("load_beats_tick", S_G1, 8'd28);
        drain();
        tick(1);
        push("disp_after_load", S_DISP, 8'h28);
        push("disp_clamp_99", S_DISP2, 8'h99);
        drain();

        // Countdown through 8 and saturating at 0
        for (int k = 1; k <= 30; k++) begin
            v = (28 - k > 0) ? 28 - k : 0;
            wait_sec();
            tick(1);
            push($sformatf("g1_dec_%0d", k), S_G1, 8'(v));
            drain();
            tick(1);
            push($sformatf("disp_dec_%0d", k), S_DISP, bcd(v));
            drain();
        end

        // Enable low clears on the next cycle
        g1_en = 1'b0;
        tick(2);
        g1_en = 1'b1;
        tick(1);
        push("reload_g1", S_G1, 8'd28);
        drain();
        g1_en = 1'b0;
        tick(1);
        push("en_low_clear", S_G1, 8'd0);
        drain();

        // Asynchronous reset mid-countdown at 12
        g1_en = 1'b1;
        tick(1);
        push("load_before_rst", S_G1, 8'd28);
        drain();
        for (int k = 1; k <= 16; k++) begin
            wait_sec();
            tick(1);
        end
        push("g1_at_12", S_G1, 8'd12);
        drain();
        #2;
        rst = 1'b0;
        #1;
        push("async_rst_g1", S_G1, 8'd0);
        push("async_rst_clk", S_CLK, 8'd0);
        push("async_rst_sec", S_SEC, 8'd0);
        push("async_rst_disp", S_DISP, 8'h00);
        drain();
        g1_en = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(3);
        push("rerelease_clk_lo", S_CLK, 8'd0);
        drain();
        tick(1);
        push("rerelease_clk_hi", S_CLK, 8'd1);
        drain();
        tick(8);
        push("no_resume_g1", S_G1, 8'd0);
        drain();
        g1_en = 1'b1;
        tick(1);
        push("resume_on_edge", S_G1, 8'd28);
        drain();

        // Hand over to direction 2 on a sec_tick cycle
        wait_sec();
        g1_en = 1'b0;
        g2_en = 1'b1;
        tick(1);
        push("g2_load", S_G2, 8'd28);
        push("g1_dropped", S_G1, 8'd0);
        drain();
        tick(1);
        push("disp_g2_28", S_DISP, 8'h28);
        drain();
        for (int k = 1; k <= 13; k++) begin
            wait_sec();
            tick(1);
            push($sformatf("g2_dec_%0d", k), S_G2, 8'(28 - k));
            drain();
        end
        tick(1);
        push("disp_g2_15", S_DISP, 8'h15);
        drain();

        // Both enables high: independent counters, display follows g1
        g1_en = 1'b1;
        tick(1);
        push("both_g1", S_G1, 8'd28);
        push("both_g2", S_G2, 8'd15);
        drain();
        tick(1);
        push("both_disp_g1", S_DISP, 8'h28);
        drain();
        wait_sec();
        tick(1);
        push("both_dec_g1", S_G1, 8'd27);
        push("both_dec_g2", S_G2, 8'd14);
        drain();
        g1_en = 1'b0;

        // Night forces zero; prescaler keeps running; day reloads
        day_night = 1'b0;
        tick(1);
        push("night_g1", S_G1, 8'd0);
        push("night_g2", S_G2, 8'd0);
        drain();
        wait_sec();
        tick(1);
        push("night_hold_g2", S_G2, 8'd0);
        drain();
        day_night = 1'b1;
        tick(1);
        push("day_reload_g2", S_G2, 8'd28);
        drain();
        for (int k = 1; k <= 21; k++) begin
            wait_sec();
            tick(1);
        end
        push("g2_at_7", S_G2, 8'd7);
        drain();
        tick(1);
        push("disp_g2_07", S_DISP, 8'h07);
        drain();

        // No enable: display blanks to 00
        g2_en = 1'b0;
        tick(2);
        push("idle_g2_clear", S_G2, 8'd0);
        push("idle_disp", S_DISP, 8'h00);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cnt_dn_timer.md
CNT_DN_TIMER -- requirements
Module: cnt_dn_timer

Interface
REQ-001 Parameter CLK_DIV, default 25_000_000: clk_fst cycles per half-second of clk_cnt_dn.
REQ-002 Parameter G_TIME, default 8'd28: seconds loaded into a green counter at the start of its phase.
REQ-003 clk_fst  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset; asynchronous, active-low (0 = reset).
REQ-005 day_night  in  1  1 = day (countdown active), 0 = night (counters held at 0).
REQ-006 g1_en  in  1  direction-1 countdown enable, driven by the light controller.
REQ-007 g2_en  in  1  direction-2 countdown enable, driven by the light controller.
REQ-008 clk_cnt_dn  out  1  registered 1 Hz square wave, 50% duty; used by the light controller as the flash source.
REQ-009 sec_tick  out  1  one-cycle pulse, once per second.
REQ-010 g1_cnt  out  8  direction-1 seconds remaining, unsigned binary.
REQ-011 g2_cnt  out  8  direction-2 seconds remaining, unsigned binary.
REQ-012 disp_bcd  out  8  registered two-digit BCD of the active counter: {tens, ones}.

Function
REQ-013 Prescaler counts 0..CLK_DIV-1 and wraps to 0. half_tick asserts on the cycle the prescaler equals CLK_DIV-1.
REQ-014 clk_cnt_dn toggles on each half_tick.
REQ-015 sec_tick asserts for exactly one cycle on the half_tick where clk_cnt_dn goes 1->0; period 2*CLK_DIV cycles.
REQ-016 The prescaler free-runs in both day and night modes and is never restarted by g1_en/g2_en.
REQ-017 Each gX_en has a registered copy used for edge detection. Rising edge of gX_en: gX_cnt <= G_TIME on that cycle, and this load takes priority over sec_tick.
REQ-018 While gX_en=1 and no rising edge: on sec_tick, gX_cnt decrements by 1; it saturates at 0 and never wraps to 255.
REQ-019 gX_en=0: gX_cnt <= 0 on the next cycle.
REQ-020 day_night=0: g1_cnt and g2_cnt are forced to 0, and edge-detect registers are cleared, so that returning to day with en=1 reloads G_TIME.
REQ-021 Both enables high simultaneously: the two counters operate independently. disp_bcd selects g1_cnt.
REQ-022 disp_bcd source: g1_cnt if g1_en, else g2_cnt if g2_en, else 8'h00. Source values >99 display 8'h99. Latency is 1 cycle after the counter change.
REQ-023 First decrement after a load occurs at the next sec_tick, which may be less than 1 s later; this is accepted behaviour.
REQ-024 G_TIME shall be at least 9 so that the controller thresholds 8 and 4 are each reached.

Reset
REQ-025 rst=0 asynchronously forces prescaler=0, clk_cnt_dn=0, sec_tick=0, g1_cnt=0, g2_cnt=0, disp_bcd=8'h00 and edge registers=0.
REQ-026 After rst release the first half_tick occurs CLK_DIV cycles later. Reset asserted mid-countdown discards all progress.

Structure
REQ-027 A shared package holds CLK_DIV_DEFAULT, G_TIME_DEFAULT, the BCD_MAX constant (99) and the count width (8).
REQ-028 One sub-module, tick_gen, contains the prescaler, clk_cnt_dn and sec_tick. Counters and BCD conversion reside in cnt_dn_timer.

Verification (CLK_DIV=4, G_TIME=28)
REQ-029 Free-run after reset, day_night=1, enables low -> clk_cnt_dn toggles every 4 cycles; sec_tick pulses every 8 cycles; g1_cnt=g2_cnt=0.
REQ-030 g1_en 0->1 -> g1_cnt=28 on the next edge; then 27, 26, ... on successive sec_ticks; reaches 8 after 20 ticks and holds at 0 after 28 ticks (no wrap).
REQ-031 g1_en rise on the same cycle as sec_tick -> g1_cnt=28, not 27.
REQ-032 g2_en high at count 15, then day_night->0 -> g2_cnt=0 next cycle; day_night->1 with g2_en still high -> reload to 28.
REQ-033 rst pulsed low asynchronously mid-countdown (g1_cnt=12) -> all outputs 0 immediately; countdown resumes only on a new g1_en rising edge.
REQ-034 g1_cnt=23 with g1_en=1 -> disp_bcd=8'h23 one cycle later; g1_en=0, g2_en=1 with g2_cnt=7 -> disp_bcd=8'h07.
